// File: rtl/pipe_if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage and the decode controller:
// FSM encodings, the bubble word and the j/jal target formation.
package pipe_if_stage_pkg;

  typedef enum logic {
    ST_BOOT  = 1'b0,
    ST_FETCH = 1'b1
  } if_state_e;

  localparam logic [31:0] C_NOP_INST = 32'h0000_0000;

  // j/jal target: upper nibble of the delay-slot PC, instr_index, word aligned.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] instr_index);
    return {pc_plus4[31:28], instr_index, 2'b00};
  endfunction

endpackage

// File: rtl/pipe_if_stage_id_reg.sv
// IF/ID pipeline register: hold wins over flush, flush wins over load.
// A flush inserts the bubble word and keeps the previous PC+4.
module pipe_if_id_reg #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_hold,
  input  logic        i_flush,
  input  logic        i_load,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc_plus4,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc_plus4,
  output logic        o_valid
);

  logic [31:0] r_inst;
  logic [31:0] r_pc_plus4;
  logic        r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst     <= NOP_INST;
      r_pc_plus4 <= 32'h0000_0000;
      r_valid    <= 1'b0;
    end else if (!i_hold) begin
      if (i_flush) begin
        r_inst  <= NOP_INST;
        r_valid <= 1'b0;
      end else if (i_load) begin
        r_inst     <= i_inst;
        r_pc_plus4 <= i_pc_plus4;
        r_valid    <= 1'b1;
      end
    end
  end

  assign o_inst     = r_inst;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage: PC, BOOT/FETCH sequencing, decode redirects and
// stalls, saturating performance counters, feeding the IF/ID register.
module pipe_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = pipe_if_stage_pkg::C_NOP_INST,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             inst_req,
  output logic [31:0]      inst_addr,
  input  logic [31:0]      inst_data,
  input  logic             MIO_ready,
  input  logic             shouldStall,
  input  logic             jump,
  input  logic [25:0]      jumpAddress,
  input  logic             jumpRs,
  input  logic [31:0]      rsData,
  input  logic             branchTaken,
  input  logic [31:0]      branchTarget,
  output logic [31:0]      id_inst,
  output logic [31:0]      id_pc_plus4,
  output logic             id_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  import pipe_if_stage_pkg::*;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  if_state_e        r_state;
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic        w_fetch;
  logic        w_advance;
  logic        w_redirect;
  logic        w_wait;
  logic        w_load;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;

  assign w_fetch    = (r_state == ST_FETCH);
  assign w_advance  = w_fetch && !shouldStall;
  assign w_redirect = w_advance && (jumpRs || jump || branchTaken);
  assign w_wait     = w_advance && !w_redirect && !MIO_ready;
  assign w_load     = w_advance && !w_redirect && MIO_ready;
  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    w_target = branchTarget;
    if (jumpRs)    w_target = rsData;
    else if (jump) w_target = jump_target(id_pc_plus4, jumpAddress);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_BOOT;
      r_pc        <= RESET_PC;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_fetch) r_state <= ST_FETCH;
      // Both the stall and the fetch-wait cases land here, counted once.
      if (w_fetch && (shouldStall || w_wait)) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_redirect) begin
        r_pc        <= {w_target[31:2], 2'b00};
        r_flush_cnt <= sat_inc(r_flush_cnt);
      end else if (w_load) begin
        r_pc <= {w_pc_plus4[31:2], 2'b00};
      end
    end
  end

  pipe_if_id_reg #(
    .NOP_INST(NOP_INST)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .i_hold    (!w_advance),
    .i_flush   (w_redirect || w_wait),
    .i_load    (w_load),
    .i_inst    (inst_data),
    .i_pc_plus4(w_pc_plus4),
    .o_inst    (id_inst),
    .o_pc_plus4(id_pc_plus4),
    .o_valid   (id_valid)
  );

  assign inst_req  = w_fetch;
  assign inst_addr = r_pc;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
